// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file command sequencer.
// FSM state encoding and the default command bundle layout.
package rf_ctrl_pkg;

  localparam int RF_DEPTH  = 8;
  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef struct packed {
    logic                 write;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/rf_cmd_fifo.sv
// Two-entry command FIFO placed ahead of the sequencer FSM.
// Registered full/empty flags; reset empties it.
module rf_cmd_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int W = CMD_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = mem_q[rp_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; push and pop may share a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Command sequencer in front of the register file: one strobe per command, one response per command.
// Optional 2-entry command queue when RF_CTRL_CMDQ_EN is defined.
module regfile_cmd_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH  = RF_DEPTH,
  parameter int MEM_WIDTH  = RF_DATA_W,
  parameter int ADDR_WIDTH = RF_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [MEM_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_WIDTH-1:0]  rsp_data,
  output logic                  rsp_err,
  output logic [MEM_WIDTH-1:0]  WrData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  input  logic [MEM_WIDTH-1:0]  RdData
);

  localparam int CW = 1 + ADDR_WIDTH + MEM_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                 state_q;
  logic                   rdy_q;
  logic                   wr_q;
  logic                   bad_q;
  logic                   wren_q;
  logic                   rden_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [MEM_WIDTH-1:0]   wdata_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [MEM_WIDTH-1:0]   rsp_data_q;

  logic                   src_vld;
  logic                   src_write;
  logic [ADDR_WIDTH-1:0]  src_addr;
  logic [MEM_WIDTH-1:0]   src_wdata;
  logic                   src_bad;
  logic                   take;

`ifdef RF_CTRL_CMDQ_EN
  // Queue mode: readiness only depends on FIFO space once out of reset.
  localparam logic HOLD_RDY = 1'b1;

  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_dout;

  rf_cmd_fifo #(
    .W (CW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (take),
    .din_i   ({cmd_write, cmd_addr, cmd_wdata}),
    .dout_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign cmd_ready = rdy_q && !q_full;
  assign src_vld   = !q_empty;
  assign {src_write, src_addr, src_wdata} = q_dout;
`else
  // Direct mode: a command is taken straight off the port in IDLE.
  localparam logic HOLD_RDY = 1'b0;

  assign cmd_ready = rdy_q;
  assign src_vld   = cmd_valid && rdy_q;
  assign src_write = cmd_write;
  assign src_addr  = cmd_addr;
  assign src_wdata = cmd_wdata;
`endif

  assign src_bad = ({1'b0, src_addr} >= DEPTH_L);
  assign take    = (state_q == IDLE) && src_vld;

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

  // Sequencer FSM; every strobe and response field is a flop set one state ahead.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      wr_q        <= 1'b0;
      bad_q       <= 1'b0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_q <= take ? HOLD_RDY : 1'b1;
          if (take) begin
            wr_q    <= src_write;
            bad_q   <= src_bad;
            state_q <= ISSUE;
            if (!src_bad) begin
              addr_q <= src_addr;
              if (src_write) begin
                wdata_q <= src_wdata;
                wren_q  <= 1'b1;
              end else begin
                rden_q  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (bad_q || wr_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bad_q;
            rsp_data_q  <= '0;
            state_q     <= RESP;
          end else begin
            state_q     <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= RdData;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_excl: assert property (@(posedge CLK) disable iff (RST)
    !(WrEn && RdEn));

  a_hold: assert property (@(posedge CLK) disable iff (RST)
    rsp_valid && !rsp_ready |=>
      rsp_valid && $stable(rsp_data) && $stable(rsp_err));

  a_one: assert property (@(posedge CLK) disable iff (RST)
    (WrEn || RdEn) |=> !(WrEn || RdEn));

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl with a behavioural 8x16 register file.
// Depth set to 6 so out-of-range addresses can be exercised.
module tb_regfile_cmd_ctrl;

  localparam int DEPTH = 6;
  localparam int DW    = 16;
  localparam int AW    = 3;
`ifdef RF_CTRL_CMDQ_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [DW-1:0] WrData;
  logic [AW-1:0] Address;
  logic          WrEn;
  logic          RdEn;
  logic [DW-1:0] RdData = '0;

  always #5 CLK = ~CLK;

  regfile_cmd_ctrl #(
    .MEM_DEPTH  (DEPTH),
    .MEM_WIDTH  (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .WrData    (WrData),
    .Address   (Address),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .RdData    (RdData)
  );

  logic [DW-1:0] rf [8];

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
  end

  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    if (RdEn) RdData <= rf[Address];
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] data;
  } vec_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return {24'h0, cmd_ready, rsp_valid, rsp_err, rsp_data,
            WrEn, RdEn, Address, WrData};
  endfunction

  always @(negedge CLK) begin : mon
    rsp_t e;
    if (!RST && (WrEn || RdEn))
      chk("strobe_legal", {62'h0, WrEn && RdEn, Address >= AW'(DEPTH)}, 0);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp", {rsp_err, rsp_data}, {e.err, e.data});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic ee,
                           input logic [DW-1:0] ed);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge CLK);
    while (!cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 1, 0);
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{ee, ed});
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      cyc(1);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 1, 0);
    cyc(1);
  endtask

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 3'd0, 16'h1111, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 3'd6, 16'hDEAD, 1'b1, 16'h0000};
    tbl[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 16'h1111};
    tbl[4]  = '{1'b0, 3'd5, 16'hFFFF, 1'b0, 16'hBEEF};
    tbl[5]  = '{1'b0, 3'd6, 16'h0000, 1'b1, 16'h0000};
    tbl[6]  = '{1'b0, 3'd7, 16'h0000, 1'b1, 16'h0000};
    tbl[7]  = '{1'b1, 3'd1, 16'hFFFF, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 3'd1, 16'h0000, 1'b0, 16'hFFFF};
    tbl[9]  = '{1'b0, 3'd3, 16'h0000, 1'b0, 16'hA5A5};
    tbl[10] = '{1'b1, 3'd3, 16'h5A5A, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 3'd3, 16'h0000, 1'b0, 16'h5A5A};

    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;

    #1 RST = 1'b1;
    #2 chk("reset_outs", outs(), 0);
    #9 RST = 1'b0;
    cyc(1);
    chk("ready_after_rst", {63'h0, cmd_ready}, 1);

    drive_cmd(1'b1, 3'd3, 16'hA5A5, 1'b0, 16'h0000);
    if (LAT > 1) cyc(LAT - 1);
    chk("wr_issue", {WrEn, RdEn, Address, WrData},
        {1'b1, 1'b0, 3'd3, 16'hA5A5});
    cyc(1);
    chk("wr_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 16'h0000});
    wait_idle();

    drive_cmd(1'b0, 3'd3, 16'h0000, 1'b0, 16'hA5A5);
    if (LAT > 1) cyc(LAT - 1);
    chk("rd_issue", {WrEn, RdEn, Address, WrData},
        {1'b0, 1'b1, 3'd3, 16'hA5A5});
    cyc(1);
    chk("rd_wait", {63'h0, rsp_valid}, 0);
    cyc(1);
    chk("rd_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 16'hA5A5});
    wait_idle();

    drive_cmd(1'b1, 3'd7, 16'h1234, 1'b1, 16'h0000);
    if (LAT > 1) cyc(LAT - 1);
    chk("err_no_strobe", {WrEn, RdEn}, 0);
    cyc(1);
    chk("err_rsp", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 16'h0000});
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      drive_cmd(tbl[i].write, tbl[i].addr, tbl[i].wdata,
                tbl[i].err, tbl[i].data);
    end
    wait_idle();

    rsp_ready = 1'b0;
    drive_cmd(1'b0, 3'd5, 16'h0000, 1'b0, 16'hBEEF);
    n = 0;
    while (!rsp_valid && n < 50) begin
      cyc(1);
      n++;
    end
    chk("stall_rsp_seen", {63'h0, rsp_valid}, 1);
`ifdef RF_CTRL_CMDQ_EN
    drive_cmd(1'b1, 3'd2, 16'h2222, 1'b0, 16'h0000);
    drive_cmd(1'b1, 3'd4, 16'h4444, 1'b0, 16'h0000);
`endif
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {rsp_valid, rsp_err, rsp_data},
          {1'b1, 1'b0, 16'hBEEF});
      chk("stall_ready", {63'h0, cmd_ready}, 0);
      cyc(1);
    end
    rsp_ready = 1'b1;
    wait_idle();

    drive_cmd(1'b1, 3'd2, 16'h7777, 1'b0, 16'h0000);
    if (LAT > 1) cyc(LAT - 1);
    chk("pre_rst_issue", {63'h0, WrEn}, 1);
    #2 RST = 1'b1;
    #1 chk("rst_cuts_strobe", outs(), 0);
    sb.delete();
    #3 RST = 1'b0;
    cyc(1);
    chk("ready_after_rst2", {63'h0, cmd_ready}, 1);

    drive_cmd(1'b0, 3'd1, 16'h0000, 1'b0, 16'hFFFF);
    cyc(LAT);
    chk("in_wait_rd", {rsp_valid, WrEn, RdEn}, 0);
    #2 RST = 1'b1;
    #1 chk("rst_in_wait_rd", outs(), 0);
    sb.delete();
    #3 RST = 1'b0;
    cyc(1);
    chk("ready_after_rst3", {63'h0, cmd_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("no_rsp_after_rst", {63'h0, rsp_valid}, 0);
      cyc(1);
    end

    drive_cmd(1'b1, 3'd4, 16'h0F0F, 1'b0, 16'h0000);
    drive_cmd(1'b0, 3'd4, 16'h0000, 1'b0, 16'h0F0F);
    drive_cmd(1'b0, 3'd1, 16'h0000, 1'b0, 16'hFFFF);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_cmd_ctrl.md
# regfile_cmd_ctrl

Command sequencer placed directly upstream of the 8 x 16 register file. Accepts read/write commands over a valid/ready handshake and converts each into a single-cycle WrEn or RdEn strobe with Address/WrData. Captures RdData and returns exactly one response per command over a second valid/ready handshake. Rejects out-of-range addresses with an error response and never issues them to the register file.

## Interface
- MEM_DEPTH, 8, number of register-file entries
- MEM_WIDTH, 16, data width
- ADDR_WIDTH, 3, address width
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target entry
- cmd_wdata  in  MEM_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at rising edge
- rsp_data  out  MEM_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  command had cmd_addr >= MEM_DEPTH
- WrData  out  MEM_WIDTH  to register file
- Address  out  ADDR_WIDTH  to register file
- WrEn  out  1  to register file, write strobe
- RdEn  out  1  to register file, read strobe
- RdData  in  MEM_WIDTH  from register file; registered there, valid the cycle after RdEn

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: cmd_ready=1. On accept, latch write/addr/wdata and go to ISSUE.
- ISSUE, addr >= MEM_DEPTH: no strobe. Set rsp_err=1, rsp_data=0. Go to RESP.
- ISSUE, write: WrEn=1, Address/WrData = latched values. Go to RESP with rsp_err=0, rsp_data=0.
- ISSUE, read: RdEn=1, Address = latched addr. Go to WAIT_RD.
- WAIT_RD: capture RdData into rsp_data at end of cycle, rsp_err=0. Go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err stay stable until rsp_ready. On handshake go to IDLE.
- Without the queue, cmd_ready=0 in ISSUE, WAIT_RD and RESP.
- WrEn and RdEn are asserted only in ISSUE, for exactly one cycle, and never together.
- Address and WrData hold their last value outside ISSUE.
- Strobes and response fields come from registers (state-decoded flops); no combinational path from cmd_* or rsp_ready to WrEn, RdEn, Address or WrData.
- Address compare is unsigned at ADDR_WIDTH bits. When MEM_DEPTH == 2**ADDR_WIDTH, no error is possible.
- Reset values: cmd_ready=0 while RST=1, then 1 in IDLE. rsp_valid, rsp_err, rsp_data, WrEn, RdEn, Address and WrData are all 0.
- RST mid-operation: FSM returns to IDLE immediately and the in-flight command is discarded with no response. If RST asserts during ISSUE, the strobe is cut short. Register-file contents are governed by its own reset.

## Timing
- Command accepted at edge 0.
- ISSUE occupies cycle 1 (WrEn/RdEn high).
- Write or error: rsp_valid rises in cycle 2.
- Read: WAIT_RD in cycle 2, rsp_valid with valid data in cycle 3.
- Best-case throughput without queue: one write per 3 cycles, one read per 4 cycles, with rsp_ready held high.
- rsp_ready held low stalls in RESP indefinitely; no response is dropped or overwritten.

## Configuration
- RF_CTRL_CMDQ_EN defined: a 2-entry command FIFO is inserted before the FSM.
  - cmd_ready = !fifo_full, independent of FSM state.
  - FSM in IDLE pops when the FIFO is non-empty, adding one cycle: ISSUE is in cycle 2 after accept.
  - Accepting and popping in the same cycle is legal.
  - RST flushes the FIFO.
- RF_CTRL_CMDQ_EN undefined: single command register, behaviour as in Operation.

## Structure
- Package rf_ctrl_pkg holds the FSM state enum (IDLE, ISSUE, WAIT_RD, RESP) and a packed command typedef {write, addr, wdata} parameterised via localparams matching the default widths.
- One sub-module: rf_cmd_fifo (2-entry, full/empty flags, async active-high reset), instantiated only under RF_CTRL_CMDQ_EN.
- The bench connects a behavioural model of the register file to WrData/Address/WrEn/RdEn/RdData.

## Test plan
- Assert RST asynchronously mid-cycle -> all outputs 0 immediately; cmd_ready=1 on the first cycle after release.
- Write addr 3, data 0xA5A5 -> cycle 1: WrEn=1, Address=3, WrData=0xA5A5. Cycle 2: rsp_valid=1, rsp_err=0, rsp_data=0.
- Read addr 3 after that write -> cycle 1: RdEn=1 only. Cycle 3: rsp_valid=1, rsp_data=0xA5A5.
- MEM_DEPTH=6, write addr 7 -> WrEn and RdEn never assert; rsp_err=1 in cycle 2; a following read of addr 7 also gives rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a read response -> rsp_valid, rsp_data and rsp_err stable. Without queue cmd_ready=0 throughout; with RF_CTRL_CMDQ_EN two more commands are accepted, then cmd_ready=0.
- Assert RST during WAIT_RD -> no rsp_valid after release; the next command completes normally.
